run_controller: RTL and testbench

Run/halt sequencer for the single-cycle MIPS datapath. It replaces the purely combinational PC enable with an FSM that does four things:
- stops the PC on a halting syscall;
- resumes exactly one instruction past that syscall on a synchronized `Go` press;
- supports single-step mode;
- optionally keeps instruction and halt statistics.

It sits between the decoder/register file outputs (`Syscall`, `R1_out`) and the PC register's write enable.

---
 rtl/run_controller.sv | 143 ++++++++++++++
 tb/tb_run_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : run_controller
//  Description : Run/halt/single-step sequencer driving the MIPS PC enable.
//                Optional statistics counters under `RUN_CTRL_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module run_controller #(
    parameter logic [31:0] PASS_CODE = 32'h0000_0022
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Syscall,
    input  logic [31:0] R1_out,
    input  logic        Go,
    input  logic        Step,
    output logic        pc_enable,
    output logic        halted,
    output logic        paused,
    output logic [31:0] instr_cnt,
    output logic [15:0] halt_cnt
);

    localparam logic [2:0] c_RUN    = 3'd0;
    localparam logic [2:0] c_HALT   = 3'd1;
    localparam logic [2:0] c_RESUME = 3'd2;
    localparam logic [2:0] c_PAUSE  = 3'd3;
    localparam logic [2:0] c_STEP   = 3'd4;

    logic       r_go_s1;
    logic       r_go_s2;
    logic       r_go_s3;
    logic       r_step_s1;
    logic       r_step_s2;
    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic       w_go_pulse;
    logic       w_hs;
    logic       w_pc_enable;

    // Go and Step are raw button levels; r_go_s3 only serves edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_go_s1   <= 1'b0;
            r_go_s2   <= 1'b0;
            r_go_s3   <= 1'b0;
            r_step_s1 <= 1'b0;
            r_step_s2 <= 1'b0;
        end else begin
            r_go_s1   <= Go;
            r_go_s2   <= r_go_s1;
            r_go_s3   <= r_go_s2;
            r_step_s1 <= Step;
            r_step_s2 <= r_step_s1;
        end
    end

    assign w_go_pulse = r_go_s2 & ~r_go_s3;
    assign w_hs       = Syscall & (R1_out != PASS_CODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_RUN, c_STEP: begin
                if (w_hs) begin
                    w_next_state = c_HALT;
                end else if (r_step_s2) begin
                    w_next_state = c_PAUSE;
                end else begin
                    w_next_state = c_RUN;
                end
            end
            c_HALT: begin
                if (w_go_pulse) begin
                    w_next_state = c_RESUME;
                end
            end
            // The syscall under the PC was already acknowledged by the halt.
            c_RESUME: begin
                w_next_state = r_step_s2 ? c_PAUSE : c_RUN;
            end
            c_PAUSE: begin
                if (w_go_pulse) begin
                    w_next_state = c_STEP;
                end
            end
            default: begin
                w_next_state = c_RUN;
            end
        endcase
    end

    always_comb begin
        w_pc_enable = 1'b0;
        case (r_state)
            c_RUN, c_STEP: w_pc_enable = ~w_hs;
            c_RESUME:      w_pc_enable = 1'b1;
            default:       w_pc_enable = 1'b0;
        endcase
    end

    assign pc_enable = w_pc_enable & ~rst;
    assign halted    = (r_state == c_HALT);
    assign paused    = (r_state == c_PAUSE);

`ifdef RUN_CTRL_STATS_EN
    logic [31:0] r_instr_cnt;
    logic [15:0] r_halt_cnt;
    logic        w_enter_halt;

    assign w_enter_halt = (r_state != c_HALT) && (w_next_state == c_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_cnt <= 32'd0;
            r_halt_cnt  <= 16'd0;
        end else begin
            if (w_pc_enable) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
            if (w_enter_halt && (r_halt_cnt != 16'hFFFF)) begin
                r_halt_cnt <= r_halt_cnt + 16'd1;
            end
        end
    end

    assign instr_cnt = r_instr_cnt;
    assign halt_cnt  = r_halt_cnt;
`else
    assign instr_cnt = 32'd0;
    assign halt_cnt  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_controller
//  Description : Self-checking bench for run_controller; follows `RUN_CTRL_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_run_controller;

`ifdef RUN_CTRL_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Syscall = 1'b0;
    logic [31:0] R1_out = 32'd0;
    logic        Go = 1'b0;
    logic        Step = 1'b0;

    logic        pc_a, hl_a, pa_a, pc_b, hl_b, pa_b;
    logic [31:0] ic_a, ic_b;
    logic [15:0] hc_a, hc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    run_controller dut_a (
        .clk(clk), .rst(rst), .Syscall(Syscall), .R1_out(R1_out), .Go(Go), .Step(Step),
        .pc_enable(pc_a), .halted(hl_a), .paused(pa_a), .instr_cnt(ic_a), .halt_cnt(hc_a)
    );

    run_controller #(.PASS_CODE(32'h0000_000A)) dut_b (
        .clk(clk), .rst(rst), .Syscall(Syscall), .R1_out(R1_out), .Go(Go), .Step(Step),
        .pc_enable(pc_b), .halted(hl_b), .paused(pa_b), .instr_cnt(ic_b), .halt_cnt(hc_b)
    );

    // Reference model: a controller is halted, paused, or running; "forced"
    // marks the one instruction released from a halt, which commits regardless.
    typedef struct {
        bit          halted;
        bit          paused;
        bit          forced;
        logic [31:0] instr;
        logic [15:0] halts;
    } mdl_t;

    mdl_t m [2];
    bit   go_q[$];
    bit   step_q[$];

    function automatic logic [31:0] pass_of(input int i);
        return (i == 0) ? 32'h22 : 32'h0A;
    endfunction

    function automatic bit m_hs(input int i);
        return Syscall && (R1_out != pass_of(i));
    endfunction

    function automatic bit m_pc(input int i);
        if (rst || m[i].halted || m[i].paused) return 1'b0;
        if (m[i].forced) return 1'b1;
        return !m_hs(i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m[i].halted = 0; m[i].paused = 0; m[i].forced = 0;
            m[i].instr = 0;  m[i].halts = 0;
        end
        go_q   = '{0, 0, 0};
        step_q = '{0, 0, 0};
    endtask

    // Called right after a rising edge, with the inputs that edge saw.
    task automatic advance();
        bit pulse, ss, pc, hs;
        if (rst) begin
            model_reset();
            return;
        end
        pulse = go_q[1] && !go_q[2];
        ss    = step_q[1];
        for (int i = 0; i < 2; i++) begin
            pc = m_pc(i);
            hs = m_hs(i);
            if (pc) m[i].instr = m[i].instr + 32'd1;
            if (m[i].halted) begin
                if (pulse) begin
                    m[i].halted = 0;
                    m[i].forced = 1;
                end
            end else if (m[i].paused) begin
                if (pulse) m[i].paused = 0;
            end else begin
                if (!m[i].forced && hs) begin
                    m[i].halted = 1;
                    if (m[i].halts != 16'hFFFF) m[i].halts = m[i].halts + 16'd1;
                end else if (ss) begin
                    m[i].paused = 1;
                end
                m[i].forced = 0;
            end
        end
        go_q.push_front(Go);
        void'(go_q.pop_back());
        step_q.push_front(Step);
        void'(step_q.pop_back());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("pc_a",     {31'd0, pc_a}, {31'd0, m_pc(0)});
        chk("halted_a", {31'd0, hl_a}, {31'd0, m[0].halted});
        chk("paused_a", {31'd0, pa_a}, {31'd0, m[0].paused});
        chk("instr_a",  ic_a, STATS_ON ? m[0].instr : 32'd0);
        chk("halts_a",  {16'd0, hc_a}, STATS_ON ? {16'd0, m[0].halts} : 32'd0);
        chk("pc_b",     {31'd0, pc_b}, {31'd0, m_pc(1)});
        chk("halted_b", {31'd0, hl_b}, {31'd0, m[1].halted});
        chk("paused_b", {31'd0, pa_b}, {31'd0, m[1].paused});
        chk("instr_b",  ic_b, STATS_ON ? m[1].instr : 32'd0);
        chk("halts_b",  {16'd0, hc_b}, STATS_ON ? {16'd0, m[1].halts} : 32'd0);
    endtask

    bit obs_pc_a, obs_hl_a, obs_pc_b;

    task automatic cycle(input bit r, input bit sc, input logic [31:0] v,
                         input bit g, input bit st);
        rst = r; Syscall = sc; R1_out = v; Go = g; Step = st;
        if (r) model_reset();
        @(negedge clk);
        obs_pc_a = pc_a; obs_hl_a = hl_a; obs_pc_b = pc_b;
        compare_all();
        @(posedge clk);
        advance();
        #1;
    endtask

    task automatic press(input bit sc, input logic [31:0] v, input bit st,
                         input int nhi, input int nlo, output int pcs);
        pcs = 0;
        for (int i = 0; i < nhi + nlo; i++) begin
            cycle(1'b0, sc, v, (i < nhi), st);
            pcs += obs_pc_a;
        end
    endtask

    typedef struct {
        bit          r;
        bit          sc;
        logic [31:0] v;
        bit          g;
        bit          st;
        bit          pc_a;
        bit          hl_a;
        bit          pc_b;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int pcs;
        logic [31:0] ic0;
        bit go_lvl, st_lvl;

        vecs[0]  = '{1, 0, 32'h00, 1, 0, 0, 0, 0};  // Go already high during reset
        vecs[1]  = '{0, 0, 32'h00, 1, 0, 1, 0, 1};
        vecs[2]  = '{0, 0, 32'h00, 0, 0, 1, 0, 1};
        vecs[3]  = '{0, 0, 32'h00, 0, 0, 1, 0, 1};  // stray pulse dropped in RUN
        vecs[4]  = '{0, 1, 32'h22, 0, 0, 1, 0, 0};  // pass code: only dut_b halts
        vecs[5]  = '{0, 1, 32'h0A, 0, 0, 0, 0, 0};  // same-cycle halt on dut_a
        vecs[6]  = '{0, 1, 32'h0A, 1, 0, 0, 1, 0};  // Go first sampled here (k)
        vecs[7]  = '{0, 1, 32'h0A, 1, 0, 0, 1, 0};
        vecs[8]  = '{0, 1, 32'h0A, 1, 0, 0, 1, 0};
        vecs[9]  = '{0, 1, 32'h0A, 1, 0, 1, 0, 1};  // RESUME commits at k+3
        vecs[10] = '{0, 1, 32'h0A, 1, 0, 0, 0, 1};
        vecs[11] = '{0, 1, 32'h0A, 1, 0, 0, 1, 1};
        vecs[12] = '{0, 0, 32'h00, 0, 0, 0, 1, 1};

        model_reset();

        // Ten plain instructions after reset
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);
        chk("instr_after_10", ic_a, STATS_ON ? 32'd10 : 32'd0);

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].sc, vecs[i].v, vecs[i].g, vecs[i].st);
            chk($sformatf("vec%0d_pc_a", i),   {31'd0, obs_pc_a}, {31'd0, vecs[i].pc_a});
            chk($sformatf("vec%0d_halt_a", i), {31'd0, obs_hl_a}, {31'd0, vecs[i].hl_a});
            chk($sformatf("vec%0d_pc_b", i),   {31'd0, obs_pc_b}, {31'd0, vecs[i].pc_b});
        end
        chk("halt_cnt_a_after_vecs", {16'd0, hc_a}, STATS_ON ? 32'd2 : 32'd0);

        // Leave HALT, then hold Go through RUN into a halting syscall
        press(0, 0, 0, 2, 3, pcs);
        chk("resumed", {31'd0, hl_a}, 32'd0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);
        pcs = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 32'h0A, 1, 0);
            pcs += obs_pc_a;
        end
        chk("held_go_no_resume_pcs", pcs, 0);
        chk("held_go_still_halted", {31'd0, hl_a}, 32'd1);
        cycle(0, 1, 32'h0A, 0, 0);
        cycle(0, 1, 32'h0A, 0, 0);
        press(1, 32'h0A, 0, 1, 5, pcs);
        chk("repress_one_commit", pcs, 1);
        chk("repress_rehalted", {31'd0, hl_a}, 32'd1);

        // Single-step mode
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
        press(0, 0, 1, 2, 4, pcs);
        chk("step_resume_pcs", pcs, 1);
        chk("step_resume_paused", {31'd0, pa_a}, 32'd1);
        for (int p = 0; p < 3; p++) begin
            ic0 = ic_a;
            press(0, 0, 1, 2, 4, pcs);
            chk($sformatf("step%0d_pcs", p), pcs, 1);
            chk($sformatf("step%0d_paused", p), {31'd0, pa_a}, 32'd1);
            chk($sformatf("step%0d_instr_delta", p), ic_a - ic0, STATS_ON ? 32'd1 : 32'd0);
        end
        press(1, 32'h0A, 1, 2, 4, pcs);
        chk("step_into_hs_pcs", pcs, 0);
        chk("step_into_hs_halted", {31'd0, hl_a}, 32'd1);
        press(1, 32'h0A, 1, 2, 4, pcs);
        chk("resume_to_pause_pcs", pcs, 1);
        chk("resume_to_pause", {31'd0, pa_a}, 32'd1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
        chk("pause_waits_for_go", {31'd0, pa_a}, 32'd1);
        press(0, 0, 0, 2, 4, pcs);
        chk("step_then_run_pcs", pcs, 3);
        chk("step_then_run_paused", {31'd0, pa_a}, 32'd0);

        // Asynchronous reset while halted
        cycle(0, 1, 32'h0A, 0, 0);
        cycle(0, 1, 32'h0A, 0, 0);
        chk("pre_rst_halted", {31'd0, hl_a}, 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_halted", {31'd0, hl_a}, 32'd0);
        chk("async_rst_pc", {31'd0, pc_a}, 32'd0);
        chk("async_rst_instr", ic_a, 32'd0);
        chk("async_rst_halts", {16'd0, hc_a}, 32'd0);
        rst = 1'b0; Syscall = 1'b0;
        @(posedge clk);
        advance();
        #1;
        cycle(0, 0, 0, 0, 0);
        chk("run_after_rst", {31'd0, obs_pc_a}, 32'd1);

        // Randomized traffic against the model
        go_lvl = 0;
        st_lvl = 0;
        for (int n = 0; n < 600; n++) begin
            bit          r, sc;
            logic [31:0] v;
            if ($urandom_range(0, 3) == 0)  go_lvl = ~go_lvl;
            if ($urandom_range(0, 29) == 0) st_lvl = ~st_lvl;
            r  = ($urandom_range(0, 149) == 0);
            sc = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0:       v = 32'h22;
                1:       v = 32'h0A;
                default: v = $urandom;
            endcase
            cycle(r, sc, v, go_lvl, st_lvl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
